// File: rtl/inverter_loopback_tester.sv
// Stimulus/response tester for the on-tile analog inverter: toggles stim_out with LFSR-spaced gaps,
// checks the synchronized response for inversion and tracks latency. Optional INVERTER_MIN_LAT_EN adds min_lat.
module inverter_loopback_tester #(
  parameter int unsigned NUM_EDGES   = 64,
  parameter int unsigned TIMEOUT     = 200,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       resp_in,
  output logic       stim_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [7:0] max_lat
`ifdef INVERTER_MIN_LAT_EN
  ,
  output logic [7:0] min_lat
`endif
);

  localparam logic [7:0] TIMEOUT_C = TIMEOUT[7:0];
  localparam logic [7:0] NUM_C     = NUM_EDGES[7:0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_GAP,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [7:0]             lfsr_q;
  logic [7:0]             cnt_q;
  logic [3:0]             gap_q;
  logic [7:0]             edge_q;
  logic                   stim_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   pass_q;
  logic [7:0]             err_q;
  logic [7:0]             max_q;
`ifdef INVERTER_MIN_LAT_EN
  logic [7:0]             min_q;
`endif

  logic       rs;
  logic       match;
  logic       last_edge;
  logic [7:0] lfsr_d;
  logic [7:0] err_d;
  logic [7:0] cnt_d;
  logic [7:0] edge_d;

  assign rs        = sync_q[SYNC_STAGES-1];
  assign match     = (rs != stim_q);
  assign lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign err_d     = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
  assign cnt_d     = cnt_q + 8'd1;
  assign edge_d    = edge_q + 8'd1;
  assign last_edge = (edge_d == NUM_C);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], resp_in};
    end
  end

  // start is a one-cycle request honoured only in IDLE or DONE; pulses while busy are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      lfsr_q  <= LFSR_SEED;
      cnt_q   <= 8'd0;
      gap_q   <= 4'd0;
      edge_q  <= 8'd0;
      stim_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 8'd0;
      max_q   <= 8'd0;
`ifdef INVERTER_MIN_LAT_EN
      min_q   <= 8'hFF;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q <= S_SETTLE;
            lfsr_q  <= LFSR_SEED;
            cnt_q   <= 8'd0;
            edge_q  <= 8'd0;
            stim_q  <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 8'd0;
            max_q   <= 8'd0;
`ifdef INVERTER_MIN_LAT_EN
            min_q   <= 8'hFF;
`endif
          end
        end
        S_SETTLE: begin
          if (rs) begin
            state_q <= S_GAP;
            gap_q   <= lfsr_q[3:0];
          end else if (cnt_d >= TIMEOUT_C) begin
            err_q   <= err_d;
            state_q <= S_GAP;
            gap_q   <= lfsr_q[3:0];
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_GAP: begin
          if (gap_q == 4'd0) begin
            stim_q  <= ~stim_q;
            lfsr_q  <= lfsr_d;
            cnt_q   <= 8'd1;
            state_q <= S_WAIT;
          end else begin
            gap_q <= gap_q - 4'd1;
          end
        end
        S_WAIT: begin
          // A match wins over a timeout landing in the same cycle.
          if (match || (cnt_q >= TIMEOUT_C)) begin
            edge_q <= edge_d;
            if (match) begin
              if (cnt_q > max_q) max_q <= cnt_q;
`ifdef INVERTER_MIN_LAT_EN
              if (cnt_q < min_q) min_q <= cnt_q;
`endif
            end else begin
              err_q <= err_d;
            end
            if (last_edge) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= match && (err_q == 8'd0);
            end else begin
              state_q <= S_GAP;
              gap_q   <= lfsr_q[3:0];
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stim_out  = stim_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign max_lat   = max_q;
`ifdef INVERTER_MIN_LAT_EN
  assign min_lat   = min_q;
`endif

endmodule

// File: tb/tb_inverter_loopback_tester.sv
// Scoreboard bench for inverter_loopback_tester: default, short-run and saturation instances
// driven by directed response patterns (ideal, delayed, tied low/high, always-late).
module tb_inverter_loopback_tester;

  typedef struct packed {
    logic        chk_lat;
    logic        chk_cyc;
    logic        pass;
    logic [7:0]  err;
    logic [7:0]  lat;
    logic [7:0]  minl;
    logic [15:0] tog;
    logic [15:0] cyc;
  } exp_t;
  localparam int W = $bits(exp_t);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] exp_d_q[$];
  logic [W-1:0] exp_s_q[$];
  logic [W-1:0] exp_t_q[$];

  logic       start_d = 1'b0, start_s = 1'b0, start_t = 1'b0;
  logic       resp_d, resp_s, resp_t;
  logic       stim_d, stim_s, stim_t;
  logic       busy_d, busy_s, busy_t;
  logic       done_d, done_s, done_t;
  logic       pass_d, pass_s, pass_t;
  logic [7:0] err_d, err_s, err_t;
  logic [7:0] lat_d, lat_s, lat_t;
  logic [7:0] min_d, min_s, min_t;

  logic       mode_d = 1'b0;
  logic       level_s = 1'b0;
  logic       arm_t = 1'b0;
  logic [9:0] dl = '1;

  always @(posedge clk) dl <= {dl[8:0], ~stim_d};
  assign resp_d = mode_d ? dl[9] : ~stim_d;
  assign resp_s = level_s;
  assign resp_t = ~stim_t & arm_t;

  inverter_loopback_tester u_def (
    .clk(clk), .rst(rst), .start(start_d), .resp_in(resp_d), .stim_out(stim_d),
    .busy(busy_d), .done(done_d), .pass(pass_d), .err_count(err_d), .max_lat(lat_d)
`ifdef INVERTER_MIN_LAT_EN
    , .min_lat(min_d)
`endif
  );

  inverter_loopback_tester #(.NUM_EDGES(4), .TIMEOUT(20)) u_short (
    .clk(clk), .rst(rst), .start(start_s), .resp_in(resp_s), .stim_out(stim_s),
    .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(err_s), .max_lat(lat_s)
`ifdef INVERTER_MIN_LAT_EN
    , .min_lat(min_s)
`endif
  );

  inverter_loopback_tester #(.NUM_EDGES(255), .TIMEOUT(1)) u_sat (
    .clk(clk), .rst(rst), .start(start_t), .resp_in(resp_t), .stim_out(stim_t),
    .busy(busy_t), .done(done_t), .pass(pass_t), .err_count(err_t), .max_lat(lat_t)
`ifdef INVERTER_MIN_LAT_EN
    , .min_lat(min_t)
`endif
  );

`ifndef INVERTER_MIN_LAT_EN
  assign min_d = 8'hFF;
  assign min_s = 8'hFF;
  assign min_t = 8'hFF;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk_exp(input logic chk_lat, input logic chk_cyc, input logic pass,
                                          input int err, input int lat, input int minl,
                                          input int tog, input int cyc);
    exp_t e;
    e.chk_lat = chk_lat;
    e.chk_cyc = chk_cyc;
    e.pass    = pass;
    e.err     = err[7:0];
    e.lat     = lat[7:0];
    e.minl    = minl[7:0];
    e.tog     = tog[15:0];
    e.cyc     = cyc[15:0];
    return e;
  endfunction

  // Busy duration of a clean run: one SETTLE cycle, then per edge a gap of LFSR[3:0]+1 plus the latency.
  function automatic int run_cycles(input int edges, input int lat);
    logic [7:0] l;
    int c;
    l = 8'hA5;
    c = 1;
    for (int i = 0; i < edges; i++) begin
      c += int'(l[3:0]) + 1 + lat;
      l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    end
    return c;
  endfunction

  task automatic check_run(input string name, input logic [W-1:0] raw, input logic busy_a,
                           input logic pass_a, input logic [7:0] err_a, input logic [7:0] lat_a,
                           input logic [7:0] min_a, input int tog_a, input int cyc_a);
    exp_t e;
    e = exp_t'(raw);
    chk({name, ".busy"}, 32'(busy_a), 32'd0);
    chk({name, ".pass"}, 32'(pass_a), 32'(e.pass));
    chk({name, ".err_count"}, 32'(err_a), 32'(e.err));
    chk({name, ".toggles"}, tog_a, 32'(e.tog));
    if (e.chk_lat) begin
      chk({name, ".max_lat"}, 32'(lat_a), 32'(e.lat));
`ifdef INVERTER_MIN_LAT_EN
      chk({name, ".min_lat"}, 32'(min_a), 32'(e.minl));
`endif
    end
    if (e.chk_cyc) chk({name, ".busy_cycles"}, cyc_a, 32'(e.cyc));
  endtask

  int   tog_d = 0, cyc_d = 0, tog_s = 0, cyc_s = 0, tog_t = 0, cyc_t = 0;
  logic bp_d = 0, bp_s = 0, bp_t = 0, dp_d = 0, dp_s = 0, dp_t = 0, sp_d = 0, sp_s = 0, sp_t = 0;

  always @(posedge clk) begin
    #1;
    if (busy_d && !bp_d) begin tog_d = 0; cyc_d = 1; end
    else begin
      if (busy_d) cyc_d++;
      if (stim_d !== sp_d) tog_d++;
    end
    if (done_d && !dp_d) begin
      if (exp_d_q.size() == 0) chk("def.unexpected_done", 32'd1, 32'd0);
      else check_run("def", exp_d_q.pop_front(), busy_d, pass_d, err_d, lat_d, min_d, tog_d, cyc_d);
    end
    bp_d = busy_d; dp_d = done_d; sp_d = stim_d;
  end

  always @(posedge clk) begin
    #1;
    if (busy_s && !bp_s) begin tog_s = 0; cyc_s = 1; end
    else begin
      if (busy_s) cyc_s++;
      if (stim_s !== sp_s) tog_s++;
    end
    if (done_s && !dp_s) begin
      if (exp_s_q.size() == 0) chk("short.unexpected_done", 32'd1, 32'd0);
      else check_run("short", exp_s_q.pop_front(), busy_s, pass_s, err_s, lat_s, min_s, tog_s, cyc_s);
    end
    bp_s = busy_s; dp_s = done_s; sp_s = stim_s;
  end

  always @(posedge clk) begin
    #1;
    if (busy_t && !bp_t) begin tog_t = 0; cyc_t = 1; end
    else begin
      if (busy_t) cyc_t++;
      if (stim_t !== sp_t) tog_t++;
    end
    if (done_t && !dp_t) begin
      if (exp_t_q.size() == 0) chk("sat.unexpected_done", 32'd1, 32'd0);
      else check_run("sat", exp_t_q.pop_front(), busy_t, pass_t, err_t, lat_t, min_t, tog_t, cyc_t);
    end
    bp_t = busy_t; dp_t = done_t; sp_t = stim_t;
  end

  task automatic pulse_start(input int which);
    @(negedge clk);
    case (which)
      0:       start_d = 1'b1;
      1:       start_s = 1'b1;
      default: start_t = 1'b1;
    endcase
    @(negedge clk);
    start_d = 1'b0;
    start_s = 1'b0;
    start_t = 1'b0;
  endtask

  task automatic wait_done(input int which, input int budget, input string name);
    logic d;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      case (which)
        0:       d = done_d;
        1:       d = done_s;
        default: d = done_t;
      endcase
      if (d) return;
    end
    chk({name, ".done_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic check_reset_values(input string name);
    chk({name, ".stim_out"}, 32'(stim_d), 32'd0);
    chk({name, ".busy"}, 32'(busy_d), 32'd0);
    chk({name, ".done"}, 32'(done_d), 32'd0);
    chk({name, ".pass"}, 32'(pass_d), 32'd0);
    chk({name, ".err_count"}, 32'(err_d), 32'd0);
    chk({name, ".max_lat"}, 32'(lat_d), 32'd0);
`ifdef INVERTER_MIN_LAT_EN
    chk({name, ".min_lat"}, 32'(min_d), 32'hFF);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_values("reset");
    repeat (5) @(negedge clk);

    // Ideal zero-delay loopback: latency is the synchronizer depth plus one.
    exp_d_q.push_back(mk_exp(1'b1, 1'b1, 1'b1, 0, 3, 3, 64, run_cycles(64, 3)));
    pulse_start(0);
    chk("ideal.busy_after_start", 32'(busy_d), 32'd1);
    wait_done(0, 3000, "ideal");

    // Ten-cycle delay line in the return path.
    mode_d = 1'b1;
    repeat (15) @(negedge clk);
    exp_d_q.push_back(mk_exp(1'b1, 1'b1, 1'b1, 0, 13, 13, 64, run_cycles(64, 13)));
    pulse_start(0);
    wait_done(0, 5000, "delay10");

    // Response tied low: SETTLE times out, and both edges expecting 1 time out.
    level_s = 1'b0;
    repeat (5) @(negedge clk);
    exp_s_q.push_back(mk_exp(1'b0, 1'b0, 1'b0, 3, 0, 0, 4, 0));
    pulse_start(1);
    wait_done(1, 1000, "tied0");

    // Response tied high: SETTLE passes, the two edges expecting 0 time out.
    level_s = 1'b1;
    repeat (5) @(negedge clk);
    exp_s_q.push_back(mk_exp(1'b0, 1'b0, 1'b0, 2, 0, 0, 4, 0));
    pulse_start(1);
    wait_done(1, 1000, "tied1");

    // Every check window is shorter than the response path: 256 errors saturate at 255.
    arm_t = 1'b0;
    repeat (5) @(negedge clk);
    exp_t_q.push_back(mk_exp(1'b1, 1'b0, 1'b0, 255, 0, 255, 255, 0));
    pulse_start(2);
    arm_t = 1'b1;
    wait_done(2, 8000, "sat");

    // A start pulse mid-run must not restart or stretch the run.
    mode_d = 1'b0;
    repeat (5) @(negedge clk);
    exp_d_q.push_back(mk_exp(1'b1, 1'b1, 1'b1, 0, 3, 3, 64, run_cycles(64, 3)));
    pulse_start(0);
    repeat (48) @(negedge clk);
    pulse_start(0);
    wait_done(0, 3000, "restart_ignored");

    // Reset 30 cycles into a run aborts to reset values on the next cycle.
    repeat (3) @(negedge clk);
    pulse_start(0);
    repeat (29) @(negedge clk);
    chk("abort.busy_before_reset", 32'(busy_d), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_values("abort");
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    chk("def.pending", exp_d_q.size(), 32'd0);
    chk("short.pending", exp_s_q.size(), 32'd0);
    chk("sat.pending", exp_t_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
